// File: rtl/chip_6502_sequencer.sv
// rtl/chip_6502_sequencer.sv - phi clock, reset and memory-bus sequencer for the netlist 6502 core
module chip_6502_sequencer #(
  parameter int SETTLE           = 4,
  parameter int RESET_PHI_CYCLES = 8
) (
  input  logic        clk,
  input  logic        res,
  input  logic        run,
  input  logic        step,
  output logic        phi,
  output logic        cpu_res,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_dbo,
  output logic [7:0]  cpu_dbi,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        stopped,
  output logic [31:0] cycle_count
);

  typedef enum logic [1:0] {PH1, PH2_REQ, PH2_HOLD, STOP} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(RESET_PHI_CYCLES);

  state_t     state;
  logic [7:0] settle_cnt;
  logic [7:0] hold_cnt;
  logic       one_shot;
  logic       settle_done;

  assign settle_done = (settle_cnt == SETTLE_LAST);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state       <= PH1;
      settle_cnt  <= 8'd0;
      hold_cnt    <= HOLD_LOAD;
      one_shot    <= 1'b0;
      phi         <= 1'b0;
      cpu_res     <= 1'b0;
      cpu_dbi     <= 8'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 16'd0;
      mem_wdata   <= 8'd0;
      stopped     <= 1'b0;
      cycle_count <= 32'd0;
    end else begin
      case (state)
        PH1: begin
          if (settle_done) begin
            settle_cnt <= 8'd0;
            mem_addr   <= cpu_ab;
            mem_we     <= ~cpu_rw;
            mem_wdata  <= cpu_dbo;
            phi        <= 1'b1;
            mem_req    <= 1'b1;
            state      <= PH2_REQ;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        PH2_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) cpu_dbi <= mem_rdata;
            state   <= PH2_HOLD;
          end
        end
        PH2_HOLD: begin
          if (settle_done) begin
            settle_cnt  <= 8'd0;
            phi         <= 1'b0;
            cycle_count <= cycle_count + 32'd1;
            if (hold_cnt != 8'd0) begin
              hold_cnt <= hold_cnt - 8'd1;
              if (hold_cnt == 8'd1) cpu_res <= 1'b1;
            end
            // A single-stepped cycle always lands back in STOP, even if run rose meanwhile.
            if (run && !one_shot) begin
              state <= PH1;
            end else begin
              state   <= STOP;
              stopped <= 1'b1;
            end
            one_shot <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        STOP: begin
          if (run) begin
            state   <= PH1;
            stopped <= 1'b0;
          end else if (step) begin
            state    <= PH1;
            stopped  <= 1'b0;
            one_shot <= 1'b1;
          end
        end
        default: state <= PH1;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_6502_sequencer.sv
// tb/tb_chip_6502_sequencer.sv - randomized self-checking bench for chip_6502_sequencer
module tb_chip_6502_sequencer;

  localparam int S = 4;
  localparam int R = 8;

  logic        clk, res, run, step, phi, cpu_res, cpu_rw, mem_req, mem_we, mem_ack, stopped;
  logic [15:0] cpu_ab, mem_addr;
  logic [7:0]  cpu_dbo, cpu_dbi, mem_wdata, mem_rdata;
  logic [31:0] cycle_count;

  int compared   = 0;
  int mismatched = 0;
  int ncycles    = 0;
  logic [7:0] dbi_model = 8'd0;
  logic [7:0] mem [logic [15:0]];

  chip_6502_sequencer #(.SETTLE(S), .RESET_PHI_CYCLES(R)) dut (
    .clk(clk), .res(res), .run(run), .step(step), .phi(phi), .cpu_res(cpu_res),
    .cpu_ab(cpu_ab), .cpu_rw(cpu_rw), .cpu_dbo(cpu_dbo), .cpu_dbi(cpu_dbi),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stopped(stopped), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] mem_read(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // One full phi cycle as seen by the core and the memory: waits = ack delay in clks after req.
  task automatic do_cycle(input int waits, input int exp_low, input logic [15:0] ab, input logic rw,
                          input logic [7:0] dbo, input bit drop_run, input bit extra_step,
                          input bit exp_stop);
    int low, high;
    logic [7:0] rdata, exp_dbi;
    logic exp_we;
    exp_we  = ~rw;
    cpu_ab  = ab;
    cpu_rw  = rw;
    cpu_dbo = dbo;
    low = 0;
    while (phi === 1'b0 && low < 1000) begin
      mem_ack   = 1'($urandom);
      mem_rdata = 8'($urandom);
      tick();
      low++;
    end
    mem_ack = 1'b0;
    compared++;
    if (low != exp_low) begin
      mismatched++;
      $display("FAIL phi_low: got %0d clk, expected %0d", low, exp_low);
    end
    compared++;
    if (cpu_dbi !== dbi_model) begin
      mismatched++;
      $display("FAIL dbi_hold_ph1: got %h expected %h", cpu_dbi, dbi_model);
    end
    compared++;
    if (mem_req !== 1'b1 || mem_addr !== ab || mem_we !== exp_we || (!rw && mem_wdata !== dbo)) begin
      mismatched++;
      $display("FAIL xfer_capture: got req=%b addr=%h we=%b wdata=%h expected req=1 addr=%h we=%b wdata=%h",
               mem_req, mem_addr, mem_we, mem_wdata, ab, exp_we, dbo);
    end
    cpu_ab  = 16'($urandom);
    cpu_rw  = 1'($urandom);
    cpu_dbo = 8'($urandom);
    if (extra_step) step = 1'b1;
    rdata   = mem_read(ab);
    exp_dbi = rw ? rdata : dbi_model;
    if (!rw) mem[ab] = dbo;
    for (int w = 0; w < waits; w++) begin
      mem_rdata = 8'($urandom);
      tick();
      step = 1'b0;
      compared++;
      if (mem_req !== 1'b1 || mem_addr !== ab || mem_we !== exp_we || phi !== 1'b1) begin
        mismatched++;
        $display("FAIL xfer_stable: got req=%b addr=%h we=%b phi=%b expected req=1 addr=%h we=%b phi=1",
                 mem_req, mem_addr, mem_we, phi, ab, exp_we);
      end
    end
    mem_ack   = 1'b1;
    mem_rdata = rw ? rdata : 8'($urandom);
    tick();
    step    = 1'b0;
    mem_ack = 1'b0;
    high    = 1 + waits;
    compared++;
    if (mem_req !== 1'b0 || cpu_dbi !== exp_dbi) begin
      mismatched++;
      $display("FAIL ack_edge: got req=%b dbi=%h expected req=0 dbi=%h", mem_req, cpu_dbi, exp_dbi);
    end
    dbi_model = exp_dbi;
    if (drop_run) run = 1'b0;
    while (phi === 1'b1 && high < 1000) begin
      tick();
      high++;
    end
    ncycles++;
    compared++;
    if (high != 1 + waits + S) begin
      mismatched++;
      $display("FAIL phi_high: got %0d clk, expected %0d", high, 1 + waits + S);
    end
    compared++;
    if (cycle_count !== 32'(ncycles)) begin
      mismatched++;
      $display("FAIL cycle_count: got %0d expected %0d", cycle_count, ncycles);
    end
    compared++;
    if (cpu_res !== (ncycles >= R)) begin
      mismatched++;
      $display("FAIL cpu_res: got %b expected %b after %0d cycles", cpu_res, (ncycles >= R), ncycles);
    end
    compared++;
    if (stopped !== exp_stop || cpu_dbi !== dbi_model) begin
      mismatched++;
      $display("FAIL cycle_end: got stopped=%b dbi=%h expected stopped=%b dbi=%h",
               stopped, cpu_dbi, exp_stop, dbi_model);
    end
  endtask

  task automatic test_reset();
    res = 1'b0; run = 1'b0; step = 1'b0; mem_ack = 1'b0; mem_rdata = 8'd0;
    cpu_ab = 16'd0; cpu_rw = 1'b1; cpu_dbo = 8'd0;
    repeat (3) tick();
    compared++;
    if ({phi, cpu_res, mem_req, mem_we, stopped} !== 5'b0) begin
      mismatched++;
      $display("FAIL reset_ctrl: got phi=%b cpu_res=%b req=%b we=%b stopped=%b expected all 0",
               phi, cpu_res, mem_req, mem_we, stopped);
    end
    compared++;
    if (mem_addr !== 16'd0 || mem_wdata !== 8'd0 || cpu_dbi !== 8'd0 || cycle_count !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_data: got addr=%h wdata=%h dbi=%h count=%0d expected 0", mem_addr, mem_wdata,
               cpu_dbi, cycle_count);
    end
  endtask

  task automatic test_reset_sequence();
    run = 1'b1;
    res = 1'b1;
    ncycles = 0;
    dbi_model = 8'd0;
    for (int i = 0; i < 10; i++)
      do_cycle(0, S, 16'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_read();
    mem[16'hFFFC] = 8'h5A;
    do_cycle(2, S, 16'hFFFC, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_write();
    do_cycle(1, S, 16'h0200, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    do_cycle(0, S, 16'h0200, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++)
      do_cycle(int'($urandom_range(0, 3)), S, 16'($urandom_range(0, 15)), 1'($urandom), 8'($urandom),
               1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stop_step();
    do_cycle(1, S, 16'($urandom), 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      mem_ack   = 1'($urandom);
      mem_rdata = 8'($urandom);
      tick();
      compared++;
      if (stopped !== 1'b1 || phi !== 1'b0 || mem_req !== 1'b0 || cpu_dbi !== dbi_model ||
          cycle_count !== 32'(ncycles)) begin
        mismatched++;
        $display("FAIL stop_idle: got stopped=%b phi=%b req=%b dbi=%h count=%0d expected 1 0 0 %h %0d",
                 stopped, phi, mem_req, cpu_dbi, cycle_count, dbi_model, ncycles);
      end
    end
    mem_ack = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    do_cycle(0, S, 16'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1);
    repeat (10) tick();
    compared++;
    if (stopped !== 1'b1 || phi !== 1'b0 || cycle_count !== 32'(ncycles)) begin
      mismatched++;
      $display("FAIL step_once: got stopped=%b phi=%b count=%0d expected 1 0 %0d", stopped, phi,
               cycle_count, ncycles);
    end
    run = 1'b1;
    tick();
    do_cycle(0, S, 16'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    cpu_ab = 16'h1234; cpu_rw = 1'b1; mem_ack = 1'b0;
    n = 0;
    while (phi !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    tick();
    #3 res = 1'b0;
    #1;
    compared++;
    if (mem_req !== 1'b0 || phi !== 1'b0 || cpu_res !== 1'b0 || cycle_count !== 32'd0 || cpu_dbi !== 8'd0) begin
      mismatched++;
      $display("FAIL async_reset: got req=%b phi=%b cpu_res=%b count=%0d dbi=%h expected all 0",
               mem_req, phi, cpu_res, cycle_count, cpu_dbi);
    end
    tick();
    res = 1'b1;
    ncycles = 0;
    dbi_model = 8'd0;
    for (int i = 0; i < 9; i++)
      do_cycle(int'($urandom_range(0, 2)), S, 16'($urandom), 1'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_reset_sequence();
    test_read();
    test_write();
    test_random();
    test_stop_step();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/chip_6502_sequencer.md
Name: chip_6502_sequencer

Overview:
Drives the netlist-level 6502 core, whose node logic advances one evaluation per FPGA clk.
- Generates the 6502 phase clock phi with a configurable number of settle clocks per half-phase.
- Sequences the CPU reset pulse.
- Turns each phi cycle's ab/rw/dbo into one request/acknowledge transfer on a shared memory bus, and holds dbi stable for the core.
- Supports free-run and single-step operation for debug.

Parameters:
SETTLE, 4, clk cycles per half-phase for node propagation (legal range 1..255).
RESET_PHI_CYCLES, 8, phi cycles cpu_res is held low after sequencer reset (legal range 1..255).

Ports:
clk  in  1  FPGA clock; all logic is on its rising edge.
res  in  1  asynchronous, active-low sequencer reset.
run  in  1  1 = free-run phi cycles; 0 = stop at the end of the current cycle.
step  in  1  one-clk pulse; when run=0 and stopped, executes exactly one phi cycle.
phi  out  1  to core clock input.
cpu_res  out  1  to core reset input (active-low).
cpu_ab  in  16  core address bus.
cpu_rw  in  1  core rw (1 = read).
cpu_dbo  in  8  core data out.
cpu_dbi  out  8  core data in (registered).
mem_req  out  1  transfer request.
mem_we  out  1  1 = write.
mem_addr  out  16  transfer address.
mem_wdata  out  8  write data.
mem_ack  in  1  transfer done; may be asserted in the same cycle as mem_req.
mem_rdata  in  8  read data, valid when mem_ack=1.
stopped  out  1  1 while in STOP.
cycle_count  out  32  completed phi cycles.

Behaviour:
Reset (res=0, asynchronous):
- State goes to PH1, with the settle counter at 0.
- phi=0, cpu_res=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_dbi=0, cycle_count=0, stopped=0.
- The reset-hold counter loads RESET_PHI_CYCLES.
- Reset mid-transfer abandons the transfer immediately. The memory side must tolerate a dropped request.

States:
- PH1: phi=0; counts SETTLE clks.
  - On the final count, captures cpu_ab, ~cpu_rw and cpu_dbo into mem_addr, mem_we and mem_wdata.
  - In the same edge, sets phi=1 and mem_req=1, then goes to PH2_REQ.
- PH2_REQ: phi=1; mem_req stays high until a clk edge samples mem_ack=1.
  - On that edge: mem_req goes to 0. If mem_we=0, cpu_dbi takes mem_rdata; if mem_we=1, cpu_dbi is unchanged.
  - Then goes to PH2_HOLD.
  - mem_addr, mem_we and mem_wdata are held constant while mem_req=1.
- PH2_HOLD: phi=1; counts SETTLE clks. On the final count:
  - phi goes to 0 and cycle_count increments (wraps at 2^32).
  - If the reset-hold counter is nonzero, it decrements; cpu_res goes to 1 on the edge where it reaches 0.
  - Next state is PH1 if run=1, else STOP.
- STOP: phi=0, stopped=1.
  - run=1 goes to PH1.
  - A step pulse goes to PH1, with a one-shot flag that forces a return to STOP after that cycle regardless of run.

Timing and rules:
- With a zero-wait ack, the phi low half is SETTLE clk, the phi high half is 1+SETTLE clk, and the period is 2*SETTLE+1 clk.
- Each memory wait state adds one clk to the phi high half.
- mem_ack while mem_req=0 is ignored.
- step while run=1, or outside STOP, is ignored.
- cpu_dbi changes only in PH2_REQ. It stays stable through the phi fall and the following PH1.
- Exactly one transfer is issued per phi cycle. The sequencer makes no dummy-cycle exceptions; the core defines bus semantics.
- The reset-hold sequence runs phi normally. Transfers still occur while cpu_res=0.
- run deasserted mid-cycle completes the current cycle, then stops.

Test Plan:
1. Reset release with run=1, SETTLE=4, RESET_PHI_CYCLES=8, zero-wait ack -> phi period is 9 clk (4 low, 5 high); cpu_res rises at the phi fall ending cycle 8; cycle_count=8 at that point.
2. Read: cpu_ab=0xFFFC, cpu_rw=1, mem_rdata=0x5A with ack on the 3rd request clk -> mem_addr=0xFFFC, mem_we=0; cpu_dbi=0x5A from the ack edge onward; phi high lasts 3+4=7 clk.
3. Write: cpu_ab=0x0200, cpu_rw=0, cpu_dbo=0xA5 -> mem_we=1, mem_wdata=0xA5, mem_addr=0x0200, all stable while req is high; cpu_dbi unchanged.
4. run=0 asserted mid-PH2_HOLD -> the cycle completes, stopped=1, phi=0. A step pulse gives exactly one more 9-clk phi cycle; cycle_count +1. A second step while running is ignored.
5. res pulled low during PH2_REQ with mem_req=1 -> in the same clk, asynchronously: mem_req=0, phi=0, cpu_res=0, cycle_count=0. After release, the full reset-hold sequence restarts.
6. mem_ack pulsed while in PH1 or STOP -> no state change; cpu_dbi unchanged.
